// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shift engine: op codes, FSM states, default sizes.
package shift_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned AMT_W = 4;

  localparam logic [2:0] SH_LSL = 3'b000;
  localparam logic [2:0] SH_LSR = 3'b001;
  localparam logic [2:0] SH_ASL = 3'b010;
  localparam logic [2:0] SH_ASR = 3'b011;
  localparam logic [2:0] SH_ROL = 3'b100;
  localparam logic [2:0] SH_ROR = 3'b101;
  localparam logic [2:0] SH_RCL = 3'b110;
  localparam logic [2:0] SH_RCR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step on the {r, c} pair; purely combinational.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = shift_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic             c,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] r_next,
  output logic             c_next
);

  always_comb begin
    r_next = r;
    c_next = c;
    case (op)
      SH_LSL, SH_ASL: begin
        c_next = r[WIDTH-1];
        r_next = {r[WIDTH-2:0], 1'b0};
      end
      SH_LSR: begin
        c_next = r[0];
        r_next = {1'b0, r[WIDTH-1:1]};
      end
      SH_ASR: begin
        c_next = r[0];
        r_next = {r[WIDTH-1], r[WIDTH-1:1]};
      end
      SH_ROL: begin
        c_next = r[WIDTH-1];
        r_next = {r[WIDTH-2:0], r[WIDTH-1]};
      end
      SH_ROR: begin
        c_next = r[0];
        r_next = {r[0], r[WIDTH-1:1]};
      end
      SH_RCL: begin
        c_next = r[WIDTH-1];
        r_next = {r[WIDTH-2:0], c};
      end
      SH_RCR: begin
        c_next = r[0];
        r_next = {c, r[WIDTH-1:1]};
      end
      default: begin
        r_next = r;
        c_next = c;
      end
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Handshaked multi-cycle shifter: accepts a request in IDLE, steps one bit per
// clock in SHIFT, and holds the result in DONE until the consumer takes it.
module shift_seq_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = shift_pkg::WIDTH,
  parameter int unsigned AMT_W = shift_pkg::AMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [AMT_W-1:0] in1,
  input  logic [2:0]       shift_type,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] shift_result,
  output logic             carry_out,
  output logic             busy
);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_r;
  logic             r_c;
  logic [2:0]       r_op;
  logic [AMT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_r_next;
  logic             w_c_next;
  logic             w_accept;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_r),
    .c      (r_c),
    .op     (r_op),
    .r_next (w_r_next),
    .c_next (w_c_next)
  );

  assign w_accept = in_valid && (r_state == ST_IDLE);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next_state = (in1 == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (r_cnt == AMT_W'(1)) w_next_state = ST_DONE;
      ST_DONE:  if (out_ready) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_r   <= '0;
      r_c   <= 1'b0;
      r_op  <= SH_LSL;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_r   <= in0;
      r_c   <= carry_in;
      r_op  <= shift_type;
      r_cnt <= in1;
    end else if (r_state == ST_SHIFT) begin
      r_r   <= w_r_next;
      r_c   <= w_c_next;
      r_cnt <= r_cnt - AMT_W'(1);
    end
  end

  // Gated by rst so a request presented during reset is never handshaked.
  assign in_ready     = (r_state == ST_IDLE) && !rst;
  assign out_valid    = (r_state == ST_DONE);
  assign busy         = (r_state != ST_IDLE);
  assign shift_result = r_r;
  assign carry_out    = r_c;

endmodule

// File: doc/shift_seq_unit.md
# shift_seq_unit

Multi-cycle, handshaked shift engine for the 16-bit ALU. It uses the same operand and op-code encoding as the combinational shifting datapath and adds carry semantics, including rotate-through-carry. Each request is processed one bit-position per clock. It connects to an upstream issue stage through a valid/ready request port and to the ALU result mux through a valid/ready response port.

## Interface
- WIDTH, 16, data width
- AMT_W, 4, shift-amount width; must equal $clog2(WIDTH)
- clk  input  1  clock; all logic rises on posedge
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  request valid
- in_ready  output  1  request ready; high only in IDLE
- in0  input  WIDTH  operand to shift
- in1  input  AMT_W  shift amount, 0..WIDTH-1
- shift_type  input  3  operation code
- carry_in  input  1  carry seed, used by RCL/RCR and for zero-amount carry
- out_valid  output  1  result valid
- out_ready  input  1  result accepted
- shift_result  output  WIDTH  shifted value
- carry_out  output  1  last bit shifted or rotated out
- busy  output  1  high in SHIFT or DONE

## Operation
- Op codes:
  - 000 LSL
  - 001 LSR
  - 010 ASL (identical to LSL)
  - 011 ASR (sign bit replicated)
  - 100 ROL
  - 101 ROR
  - 110 RCL: 17-bit rotate left through carry
  - 111 RCR: 17-bit rotate right through carry
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch in0→r, shift_type→op, in1→cnt, carry_in→c.
  - Go to DONE if in1==0, else go to SHIFT.
- SHIFT: each cycle applies one 1-bit step to {r,c} and decrements cnt.
  - When the step is taken with cnt==1, go to DONE.
- One-bit steps:
  - LSL/ASL: c←r[15], r←{r[14:0],0}
  - LSR: c←r[0], r←{0,r[15:1]}
  - ASR: c←r[0], r←{r[15],r[15:1]}
  - ROL: c←r[15], r←{r[14:0],r[15]}
  - ROR: c←r[0], r←{r[0],r[15:1]}
  - RCL: c←r[15], r←{r[14:0],c}
  - RCR: c←r[0], r←{c,r[15:1]}
- DONE:
  - out_valid=1; shift_result=r and carry_out=c, held stable.
  - On out_ready, go to IDLE.
- Zero amount: result=in0 and carry_out=carry_in for every op.
- in_valid is ignored outside IDLE; no queuing, no same-cycle bypass from DONE to accept.

## Timing
- Reset values: state IDLE, out_valid 0, shift_result 0, carry_out 0, busy 0, cnt 0.
- in_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.
- Latency: out_valid rises N+1 cycles after the accept edge, where N=in1 (N=0 gives 1 cycle).
- Minimum occupancy per request: accept cycle + N + 1 DONE cycle. The next accept is possible no earlier than the cycle after the DONE handshake.
- Backpressure: with out_ready low, out_valid, shift_result and carry_out hold indefinitely and in_ready stays 0.
- shift_result and carry_out are registered outputs; they change only at accept, on SHIFT steps, or at reset. They are meaningful only while out_valid=1.
- rst asserted in any state, including mid-SHIFT or in DONE with out_valid=1, aborts the operation. All outputs return to their reset values at that edge and the result is not delivered.
- rst and in_valid high in the same cycle: reset wins and nothing is accepted.

## Structure
- Shared package shift_pkg holds:
  - localparams for the eight op codes (SH_LSL … SH_RCR)
  - the state encoding for IDLE/SHIFT/DONE
  - the default WIDTH/AMT_W
- The combinational datapath sub-module shift_step computes the one-bit step:
  - inputs: r, c, op
  - outputs: r_next, c_next
- The top-level holds the FSM, counter and registers.

## Test plan
- LSL in0=0x0001, in1=1, out_ready=1 → out_valid 2 cycles after accept, shift_result=0x0002, carry_out=0.
- LSR 0xF000 by 4 → 0x0F00, carry 0; ASR 0x8000 by 1 → 0xC000, carry 0; ASR 0x7000 by 1 → 0x3800.
- ROL 0x8001 by 1 → 0x0003, carry 1; ROR 0x0003 by 1 → 0x8001, carry 1; RCL 0x8000 by 1 with carry_in=0 → 0x0000, carry 1; RCR 0x0001 by 1 with carry_in=1 → 0x8000, carry 1.
- Zero amount: 0x1234 by 0, LSL, carry_in=1 → out_valid 1 cycle after accept, 0x1234, carry 1. Also 0x8000 LSL by 15 → 0x0000, carry 0, latency 16.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → outputs stable and in_ready=0 throughout; a new in_valid during that time is not accepted. Accept occurs 1 cycle after the handshake.
- Reset mid-op: start LSL by 10, assert rst after 4 SHIFT cycles → next cycle out_valid=0, busy=0, shift_result=0. After release, a fresh request completes correctly.
